// File: rtl/pwm_hum_ramp_if.sv
// Bundle between the humidity decode, the motor driver pins and the PWM ramp.
// The master side supplies enable and humidity. The slave side returns PWM and status.
interface pwm_hum_ramp_if #(
  parameter int unsigned CH = 2,
  parameter int unsigned CW = 10
);
  logic              en;
  logic [4*CH-1:0]   humidity10;
  logic [CH-1:0]     pwm;
  logic              period_tick;
  logic [CH-1:0]     busy;
  logic [CW*CH-1:0]  duty_now;

  modport master (
    output en, humidity10,
    input  pwm, period_tick, busy, duty_now
  );

  modport slave (
    input  en, humidity10,
    output pwm, period_tick, busy, duty_now
  );
endinterface

// File: rtl/pwm_hum_ramp.sv
// Multi-channel humidity-driven PWM with a soft-start duty ramp.
// The applied duty slews toward a banded target by at most STEP counts per period.
module pwm_hum_ramp #(
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned CW       = 10,
  parameter int unsigned CH       = 2,
  parameter int unsigned STEP     = 20,
  parameter int unsigned PCT_LT20 = 80,
  parameter int unsigned PCT_LT50 = 50,
  parameter int unsigned PCT_LT80 = 20
) (
  input  logic            clk,
  input  logic            rst,
  pwm_hum_ramp_if.slave   bus
);

  localparam logic [CW:0]   STEP_X = (CW+1)'(STEP);
  localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);

  function automatic logic [CW-1:0] target_of(input logic [3:0] h);
    int unsigned pct;
    pct = 0;
    if (h <= 4'd1)      pct = PCT_LT20;
    else if (h <= 4'd4) pct = PCT_LT50;
    else if (h <= 4'd7) pct = PCT_LT80;
    return CW'((PERIOD * pct) / 100);
  endfunction

  logic [CW-1:0] cnt;
  logic          tick;
  logic          tick_q;
  logic [CH-1:0] pwm_q;
  logic [CW-1:0] cur   [CH];
  logic [CW-1:0] tgt_q [CH];
  logic [CW-1:0] tgt   [CH];
  logic [CW-1:0] nxt   [CH];

  assign tick = bus.en && (cnt == LAST);

  // Slew arithmetic is one bit wider so neither cur+STEP nor cur-STEP can wrap.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      tgt[i] = target_of(bus.humidity10[4*i +: 4]);
      nxt[i] = cur[i];
      if ({1'b0, cur[i]} < {1'b0, tgt[i]}) begin
        if ({1'b0, cur[i]} + STEP_X >= {1'b0, tgt[i]}) nxt[i] = tgt[i];
        else                                         nxt[i] = CW'({1'b0, cur[i]} + STEP_X);
      end else if ({1'b0, cur[i]} > {1'b0, tgt[i]}) begin
        if ({1'b0, cur[i]} - {1'b0, tgt[i]} <= STEP_X) nxt[i] = tgt[i];
        else                                           nxt[i] = CW'({1'b0, cur[i]} - STEP_X);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        cur[i]   <= '0;
        tgt_q[i] <= '0;
      end
    end else if (!bus.en) begin
      cnt    <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        cur[i]   <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      cnt    <= tick ? '0 : cnt + CW'(1);
      tick_q <= tick;
      for (int unsigned i = 0; i < CH; i++) begin
        // Compare uses the pre-tick duty, so a new duty starts exactly at counter 0.
        pwm_q[i] <= (cnt < cur[i]);
        if (tick) begin
          cur[i]   <= nxt[i];
          tgt_q[i] <= tgt[i];
        end
      end
    end
  end

  always_comb begin
    bus.duty_now = '0;
    bus.busy     = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      bus.duty_now[CW*i +: CW] = cur[i];
      bus.busy[i]              = (cur[i] != tgt_q[i]);
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.period_tick = tick_q;

endmodule

// File: doc/pwm_hum_ramp.md
# pwm_hum_ramp

Multi-channel, humidity-driven PWM motor/fan controller with a soft-start duty ramp. Each channel maps its humidity tens-digit (0..15 = 0..150 %) to a target duty through a three-band table. The applied duty then slews toward that target by a bounded step once per PWM period, so duty changes are glitch-free and current-limited. The block sits between the DHT11 humidity decode and the motor driver pins. It replaces the single-channel fixed-step PWM.

## Interface
- PERIOD, 1000: PWM period in clk cycles; the counter runs 0..PERIOD-1.
- CW, 10: counter/duty width; requires 2^CW >= PERIOD+1.
- CH, 2: number of independent channels, 1..8.
- STEP, 20: maximum duty change per period, in counts; 1..PERIOD.
- PCT_LT20, 80: duty percent for humidity10 0..1.
- PCT_LT50, 50: duty percent for humidity10 2..4.
- PCT_LT80, 20: duty percent for humidity10 5..7. All humidity10 values 8..15 give 0 %.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low forces all outputs off and resets the ramp.
- humidity10  in  4*CH  tens digit per channel; channel i uses bits [4i+3:4i].
- pwm  out  CH  registered PWM outputs.
- period_tick  out  1  registered one-cycle pulse in the cycle after the counter equals PERIOD-1.
- busy  out  CH  registered; high while the channel's applied duty differs from its latched target.
- duty_now  out  CW*CH  applied duty per channel, in counts.

## Operation
- Target, combinational per channel: T = (PERIOD*pct)/100, using the pct band selected by humidity10. Evaluated at 32-bit integer width with truncation; PERIOD=1000 gives 800/500/200/0.
- Counter: shared by all channels; increments every cycle while en=1 and wraps PERIOD-1 -> 0.
- Tick: the cycle where en=1 and counter==PERIOD-1. On a tick, for every channel:
  - tgt_q <= T, sampled from humidity10 at that cycle only; humidity changes mid-period are ignored until the next tick.
  - cur <= min(cur+STEP, T) if cur<T.
  - cur <= max(cur-STEP, T) if cur>T; computed at CW+1 bits with no underflow.
  - cur is unchanged if cur==T.
  - busy <= (new cur != T).
- PWM output: each cycle, pwm[i] <= en & (counter < cur[i]). Over a full period this gives exactly cur[i] high cycles, starting at counter 0. cur=0 gives constant low; cur=PERIOD gives constant high.
- duty_now[i] = cur[i], taken directly from the register.
- en=0, synchronous: counter<=0, cur<=0, tgt_q<=0, busy<=0, pwm<=0, period_tick<=0. On en returning high, the counter starts from 0 and each channel soft-starts from duty 0.
- Channels are fully independent apart from the shared counter and tick.

## Timing
- Reset (rst=0, asynchronous) sets counter, cur, tgt_q, pwm, busy and period_tick all to 0. Outputs stay 0 until the first enabled cycle after release.
- pwm lags the counter by 1 cycle. The first pwm-high cycle of a period is the cycle after counter==0.
- A new cur takes effect at the very next counter==0 compare. Duty never changes inside a period.
- period_tick asserts in the same cycle that the new cur, busy and tgt_q values become visible.
- Target-to-full-duty latency is ceil(|T-cur|/STEP) ticks. busy deasserts on the tick that reaches T.
- Reset asserted mid-period: all state clears immediately. No partial period is resumed after release.
- en low on the tick cycle: the en=0 behaviour wins and no ramp step is applied.

## Test plan
- Reset/idle, PERIOD=100, STEP=20, humidity10=0, en=1 after reset:
  - duty_now steps 20, 40, 60, 80 on successive ticks.
  - busy drops on the 4th tick.
  - pwm is then high for exactly 80 of each 100 cycles.
- Ramp down: after settling at 80, set humidity10=9:
  - duty_now steps 60, 40, 20, 0.
  - pwm then stays low.
  - busy=1 for ticks 1..3 and 0 after tick 4.
- Mid-period change: change humidity10 from 3 to 6 and back to 3 at counter=40, before the tick:
  - tgt_q and duty_now stay at 50.
  - pwm high count for that period is 50.
- Enable drop: at duty 80, pull en low for 5 cycles, then high:
  - pwm and duty_now go 0 the next cycle.
  - The counter restarts at 0 and the ramp resumes 20, 40, ...
- Channel independence with CH=2, ch0 humidity10=1, ch1 humidity10=12:
  - ch0 ramps to 80 while ch1 stays at 0 with busy[1]=0.
  - period_tick pulses once every 100 cycles.
- Async reset mid-period: assert rst at counter=37 between clock edges:
  - pwm, busy and duty_now go 0 before the next edge.
  - After release the counter starts at 0.
